// File: rtl/cg_pkg.sv
// Shared definitions for the conjugate-gradient iteration sequencer: state
// encoding, stage bit positions and the element-width default.
package cg_pkg;

    localparam int CG_ELEM_W  = 32;
    localparam int NUM_STAGES = 7;

    localparam int STG_RR0   = 0;
    localparam int STG_AP    = 1;
    localparam int STG_ALPHA = 2;
    localparam int STG_UPD   = 3;
    localparam int STG_RRNEW = 4;
    localparam int STG_BETA  = 5;
    localparam int STG_PUPD  = 6;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RR0     = 4'd1,
        ST_AP      = 4'd2,
        ST_ALPHA   = 4'd3,
        ST_UPD     = 4'd4,
        ST_RRNEW   = 4'd5,
        ST_CHECK   = 4'd6,
        ST_BETA    = 4'd7,
        ST_PUPD    = 4'd8,
        ST_FIN     = 4'd9,
        ST_ABORTED = 4'd10
    } cg_state_t;

    // Maps a stage state to its one-hot stage bit; non-stage states map to zero.
    function automatic logic [NUM_STAGES-1:0] stage_onehot(input cg_state_t st);
        logic [NUM_STAGES-1:0] oh_s;
        oh_s = '0;
        case (st)
            ST_RR0:   oh_s[STG_RR0]   = 1'b1;
            ST_AP:    oh_s[STG_AP]    = 1'b1;
            ST_ALPHA: oh_s[STG_ALPHA] = 1'b1;
            ST_UPD:   oh_s[STG_UPD]   = 1'b1;
            ST_RRNEW: oh_s[STG_RRNEW] = 1'b1;
            ST_BETA:  oh_s[STG_BETA]  = 1'b1;
            ST_PUPD:  oh_s[STG_PUPD]  = 1'b1;
            default:  oh_s = '0;
        endcase
        return oh_s;
    endfunction

endpackage

// File: rtl/cg_iteration_sequencer_if.sv
// Stage-control and dot-product read-beat bus between the sequencer (master)
// and the arithmetic units (slave).
interface cg_iteration_sequencer_if
    import cg_pkg::*;
#(
    parameter int ELEM_W = CG_ELEM_W,
    parameter int LEN_W  = 32
) ();

    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_done;
    logic                  rd_valid;
    logic                  rd_ready;
    logic                  rd_last;
    logic [LEN_W-1:0]      rd_beat;
    logic [ELEM_W-1:0]     rr_result;

    modport master (
        output stage_start, rd_valid, rd_last, rd_beat,
        input  stage_done, rd_ready, rr_result
    );

    modport slave (
        input  stage_start, rd_valid, rd_last, rd_beat,
        output stage_done, rd_ready, rr_result
    );

endinterface

// File: rtl/cg_beat_gen.sv
// Issues beat indices 0..nbeats-1 over a valid/ready handshake for one
// dot-product pass; rd_last marks the final beat.
module cg_beat_gen
    import cg_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic [LEN_W-1:0] nbeats,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [LEN_W-1:0] rd_beat,
    output logic             rd_last
);

    logic             valid_r;
    logic [LEN_W-1:0] beat_r;
    logic             last_r;

    // Beat counter; clear wins over start so a pass abandoned mid-flight stops at once.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid_r <= 1'b0;
            beat_r  <= '0;
            last_r  <= 1'b0;
        end else if (start) begin
            valid_r <= (nbeats != LEN_W'(0));
            beat_r  <= '0;
            last_r  <= (nbeats == LEN_W'(1));
        end else if (valid_r && rd_ready) begin
            if (last_r) begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                beat_r <= beat_r + LEN_W'(1);
                last_r <= ((beat_r + LEN_W'(2)) == nbeats);
            end
        end
    end

    assign rd_valid = valid_r;
    assign rd_beat  = beat_r;
    assign rd_last  = last_r;

endmodule

// File: rtl/cg_iteration_sequencer.sv
// Control sequencer for one conjugate-gradient solve: steps the arithmetic
// stages, tracks r.r convergence and iteration count, with watchdog and abort.
module cg_iteration_sequencer
    import cg_pkg::*;
#(
    parameter int ELEM_W    = CG_ELEM_W,
    parameter int NUM_LANES = 8,
    parameter int LEN_W     = 32,
    parameter int ITER_W    = 16,
    parameter int WD_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     abort,
    input  logic [LEN_W-1:0]         vec_len,
    input  logic [ITER_W-1:0]        max_iter,
    input  logic [ELEM_W-1:0]        tolerance,
    cg_iteration_sequencer_if.master bus,
    output logic [ELEM_W-1:0]        rs_old,
    output logic [ELEM_W-1:0]        rs_new,
    output logic [ITER_W-1:0]        iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     error
);

    localparam int               LANE_SH   = $clog2(NUM_LANES);
    localparam logic [LEN_W-1:0] LANE_MASK = LEN_W'(NUM_LANES - 1);
    localparam int               WD_W      = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(WD_CYCLES - 1);

    cg_state_t             state_r;
    logic [NUM_STAGES-1:0] stage_start_r;
    logic [ELEM_W-1:0]     rs_old_r;
    logic [ELEM_W-1:0]     rs_new_r;
    logic [ITER_W-1:0]     iter_count_r;
    logic [ITER_W-1:0]     max_iter_r;
    logic [ELEM_W-2:0]     tol_r;
    logic [LEN_W-1:0]      nbeats_r;
    logic [WD_W-1:0]       wd_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  converged_r;
    logic                  error_r;

    logic [LEN_W-1:0] nbeats_s;
    logic             stage_hit_s;
    logic             wd_expire_s;
    logic             rs_conv_s;
    logic             iter_limit_s;
    logic             beat_start_s;
    logic             beat_clear_s;
    logic             rd_valid_s;
    logic             rd_last_s;
    logic [LEN_W-1:0] rd_beat_s;
    logic             unused_tol_sign_s;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + ITER_W'(1);
        end
    endfunction

    // ceil(vec_len / NUM_LANES) without risking overflow of vec_len + NUM_LANES - 1
    assign nbeats_s     = (vec_len >> LANE_SH) +
                          (((vec_len & LANE_MASK) != LEN_W'(0)) ? LEN_W'(1) : LEN_W'(0));
    assign stage_hit_s  = |(bus.stage_done & stage_onehot(state_r));
    assign wd_expire_s  = (wd_r == WD_LAST);
    // Negative r.r is treated as converged; magnitudes compare as unsigned bit patterns.
    assign rs_conv_s    = rs_new_r[ELEM_W-1] || (rs_new_r[ELEM_W-2:0] <= tol_r);
    assign iter_limit_s = (({1'b0, iter_count_r} + {{ITER_W{1'b0}}, 1'b1}) == {1'b0, max_iter_r});
    assign beat_start_s = stage_start_r[STG_RR0] | stage_start_r[STG_RRNEW];
    assign beat_clear_s = ((state_r != ST_RR0) && (state_r != ST_RRNEW)) ||
                          stage_hit_s || wd_expire_s || abort;
    assign unused_tol_sign_s = tolerance[ELEM_W-1];

    cg_beat_gen #(.LEN_W(LEN_W)) u_beat_gen (
        .clk      (clk),
        .reset    (reset),
        .start    (beat_start_s),
        .clear    (beat_clear_s),
        .nbeats   (nbeats_r),
        .rd_ready (bus.rd_ready),
        .rd_valid (rd_valid_s),
        .rd_beat  (rd_beat_s),
        .rd_last  (rd_last_s)
    );

    // Solve sequencer: state, stage start pulses, watchdog and all status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            stage_start_r <= '0;
            rs_old_r      <= '0;
            rs_new_r      <= '0;
            iter_count_r  <= '0;
            max_iter_r    <= '0;
            tol_r         <= '0;
            nbeats_r      <= '0;
            wd_r          <= '0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            converged_r   <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            stage_start_r <= '0;
            if (abort && (state_r != ST_IDLE)) begin
                state_r     <= ST_ABORTED;
                busy_r      <= 1'b0;
                done_r      <= 1'b1;
                converged_r <= 1'b0;
                error_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_FIN, ST_ABORTED: begin
                        if (go) begin
                            max_iter_r   <= max_iter;
                            tol_r        <= tolerance[ELEM_W-2:0];
                            nbeats_r     <= nbeats_s;
                            iter_count_r <= '0;
                            rs_old_r     <= '0;
                            rs_new_r     <= '0;
                            wd_r         <= '0;
                            error_r      <= 1'b0;
                            if ((vec_len == LEN_W'(0)) || (max_iter == ITER_W'(0))) begin
                                state_r     <= ST_FIN;
                                busy_r      <= 1'b0;
                                done_r      <= 1'b1;
                                converged_r <= 1'b1;
                            end else begin
                                state_r       <= ST_RR0;
                                stage_start_r <= stage_onehot(ST_RR0);
                                busy_r        <= 1'b1;
                                done_r        <= 1'b0;
                                converged_r   <= 1'b0;
                            end
                        end
                    end
                    ST_RR0, ST_AP, ST_ALPHA, ST_UPD, ST_RRNEW, ST_BETA, ST_PUPD: begin
                        if (stage_hit_s) begin
                            wd_r <= '0;
                            case (state_r)
                                ST_RR0: begin
                                    rs_old_r      <= bus.rr_result;
                                    state_r       <= ST_AP;
                                    stage_start_r <= stage_onehot(ST_AP);
                                end
                                ST_AP: begin
                                    state_r       <= ST_ALPHA;
                                    stage_start_r <= stage_onehot(ST_ALPHA);
                                end
                                ST_ALPHA: begin
                                    state_r       <= ST_UPD;
                                    stage_start_r <= stage_onehot(ST_UPD);
                                end
                                ST_UPD: begin
                                    state_r       <= ST_RRNEW;
                                    stage_start_r <= stage_onehot(ST_RRNEW);
                                end
                                ST_RRNEW: begin
                                    rs_new_r <= bus.rr_result;
                                    state_r  <= ST_CHECK;
                                end
                                ST_BETA: begin
                                    state_r       <= ST_PUPD;
                                    stage_start_r <= stage_onehot(ST_PUPD);
                                end
                                ST_PUPD: begin
                                    rs_old_r      <= rs_new_r;
                                    iter_count_r  <= sat_inc(iter_count_r);
                                    state_r       <= ST_AP;
                                    stage_start_r <= stage_onehot(ST_AP);
                                end
                                default: state_r <= ST_IDLE;
                            endcase
                        end else if (wd_expire_s) begin
                            state_r     <= ST_FIN;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            converged_r <= 1'b0;
                            error_r     <= 1'b1;
                        end else begin
                            wd_r <= wd_r + WD_W'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (rs_conv_s || iter_limit_s) begin
                            iter_count_r <= sat_inc(iter_count_r);
                            state_r      <= ST_FIN;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                            converged_r  <= rs_conv_s;
                        end else begin
                            wd_r          <= '0;
                            state_r       <= ST_BETA;
                            stage_start_r <= stage_onehot(ST_BETA);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.stage_start = stage_start_r;
    assign bus.rd_valid    = rd_valid_s;
    assign bus.rd_beat     = rd_beat_s;
    assign bus.rd_last     = rd_last_s;
    assign rs_old          = rs_old_r;
    assign rs_new          = rs_new_r;
    assign iter_count      = iter_count_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign converged       = converged_r;
    assign error           = error_r;

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Directed self-checking bench for cg_iteration_sequencer: plays the stage units
// by hand and compares outputs against hand-computed values.
module tb_cg_iteration_sequencer;
    import cg_pkg::*;

    localparam int ELEM_W    = 32;
    localparam int NUM_LANES = 8;
    localparam int LEN_W     = 32;
    localparam int ITER_W    = 16;
    localparam int WD_CYCLES = 16;
    localparam logic [31:0] TOL = 32'h283424DC;

    logic              clk = 1'b0;
    logic              reset;
    logic              go;
    logic              abort;
    logic [LEN_W-1:0]  vec_len;
    logic [ITER_W-1:0] max_iter;
    logic [ELEM_W-1:0] tolerance;
    logic [ELEM_W-1:0] rs_old;
    logic [ELEM_W-1:0] rs_new;
    logic [ITER_W-1:0] iter_count;
    logic              busy;
    logic              done;
    logic              converged;
    logic              error;

    int n_checks = 0;
    int n_errors = 0;

    cg_iteration_sequencer_if #(.ELEM_W(ELEM_W), .LEN_W(LEN_W)) bus ();

    cg_iteration_sequencer #(
        .ELEM_W(ELEM_W), .NUM_LANES(NUM_LANES), .LEN_W(LEN_W),
        .ITER_W(ITER_W), .WD_CYCLES(WD_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .vec_len(vec_len), .max_iter(max_iter), .tolerance(tolerance),
        .bus(bus),
        .rs_old(rs_old), .rs_new(rs_new), .iter_count(iter_count),
        .busy(busy), .done(done), .converged(converged), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_stage(input int idx, input string tag);
        logic [6:0] exp_oh;
        int n;
        exp_oh = 7'd1 << idx;
        n = 0;
        while ((bus.stage_start !== exp_oh) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.stage_start), 32'(exp_oh));
    endtask

    task automatic pulse_done(input int idx, input logic [31:0] rr);
        bus.stage_done = 7'd1 << idx;
        bus.rr_result  = rr;
        @(negedge clk);
        bus.stage_done = '0;
    endtask

    task automatic start_solve(input logic [31:0] vl, input logic [15:0] mi);
        vec_len   = vl;
        max_iter  = mi;
        tolerance = TOL;
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
    endtask

    task automatic step(input int idx, input string tag, input logic [31:0] rr);
        wait_stage(idx, tag);
        pulse_done(idx, rr);
    endtask

    initial begin
        int beats[$];
        int lasts[$];
        int acc[$];
        logic held_pending;
        logic [31:0] held_b;

        reset = 1'b1; go = 1'b1; abort = 1'b0;
        vec_len = 32'd20; max_iter = 16'd10; tolerance = TOL;
        bus.stage_done = '0; bus.rd_ready = 1'b0; bus.rr_result = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stage_start", 32'(bus.stage_start), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_iter", 32'(iter_count), 32'd0);
        chk("rst_rs", rs_old | rs_new, 32'd0);
        reset = 1'b0; go = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Converging solve: beats of RR0, one BETA/PUPD loop, converge on second RRNEW
        bus.rd_ready = 1'b1;
        start_solve(32'd20, 16'd10);
        chk("a_busy", 32'(busy), 32'd1);
        wait_stage(STG_RR0, "a_rr0_start");
        for (int i = 0; i < 8; i++) begin
            if (bus.rd_valid) begin
                beats.push_back(int'(bus.rd_beat));
                if (bus.rd_last) lasts.push_back(int'(bus.rd_beat));
            end
            @(negedge clk);
        end
        chk("a_nbeats", 32'(beats.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            chk("a_beat", (k < beats.size()) ? 32'(beats[k]) : 32'hFFFF_FFFF, 32'(k));
        chk("a_last_beat", (lasts.size() == 1) ? 32'(lasts[0]) : 32'hFFFF_FFFF, 32'd2);
        chk("a_rd_valid_end", 32'(bus.rd_valid), 32'd0);
        pulse_done(STG_RR0, 32'h4000_0000);
        wait_stage(STG_AP, "a_ap_start");
        chk("a_rs_old0", rs_old, 32'h4000_0000);
        bus.stage_done = 7'd1 << STG_BETA;
        @(negedge clk);
        bus.stage_done = '0;
        chk("a_foreign_done", 32'(bus.stage_start), 32'd0);
        pulse_done(STG_AP, 32'd0);
        step(STG_ALPHA, "a_alpha", 32'd0);
        step(STG_UPD, "a_upd", 32'd0);
        step(STG_RRNEW, "a_rrnew1", 32'h3F80_0000);
        chk("a_check_gap", 32'(bus.stage_start), 32'd0);
        chk("a_rs_new1", rs_new, 32'h3F80_0000);
        step(STG_BETA, "a_beta", 32'd0);
        step(STG_PUPD, "a_pupd", 32'd0);
        wait_stage(STG_AP, "a_ap2_start");
        chk("a_iter1", 32'(iter_count), 32'd1);
        chk("a_rs_old1", rs_old, 32'h3F80_0000);
        pulse_done(STG_AP, 32'd0);
        step(STG_ALPHA, "a_alpha2", 32'd0);
        step(STG_UPD, "a_upd2", 32'd0);
        step(STG_RRNEW, "a_rrnew2", 32'h2000_0000);
        @(negedge clk);
        chk("a_done", 32'(done), 32'd1);
        chk("a_converged", 32'(converged), 32'd1);
        chk("a_iter2", 32'(iter_count), 32'd2);
        chk("a_busy_end", 32'(busy), 32'd0);
        chk("a_error", 32'(error), 32'd0);

        // Toggling rd_ready, then iteration limit without convergence
        bus.rd_ready = 1'b0;
        start_solve(32'd16, 16'd3);
        chk("b_done_cleared", 32'(done), 32'd0);
        chk("b_iter_cleared", 32'(iter_count), 32'd0);
        wait_stage(STG_RR0, "b_rr0_start");
        held_pending = 1'b0;
        held_b = '0;
        for (int i = 0; i < 10; i++) begin
            if (held_pending) begin
                chk("b_hold_valid", 32'(bus.rd_valid), 32'd1);
                chk("b_hold_beat", bus.rd_beat, held_b);
                held_pending = 1'b0;
            end
            bus.rd_ready = i[0];
            if (bus.rd_valid && bus.rd_ready) begin
                acc.push_back(int'(bus.rd_beat));
            end else if (bus.rd_valid) begin
                held_pending = 1'b1;
                held_b = bus.rd_beat;
            end
            @(negedge clk);
        end
        chk("b_nbeats", 32'(acc.size()), 32'd2);
        for (int k = 0; k < 2; k++)
            chk("b_beat", (k < acc.size()) ? 32'(acc[k]) : 32'hFFFF_FFFF, 32'(k));
        bus.rd_ready = 1'b1;
        pulse_done(STG_RR0, 32'h4000_0000);
        for (int it = 1; it <= 3; it++) begin
            wait_stage(STG_AP, "b_ap");
            chk("b_iter_progress", 32'(iter_count), 32'(it - 1));
            pulse_done(STG_AP, 32'd0);
            step(STG_ALPHA, "b_alpha", 32'd0);
            step(STG_UPD, "b_upd", 32'd0);
            step(STG_RRNEW, "b_rrnew", 32'h3F80_0000);
            if (it < 3) begin
                step(STG_BETA, "b_beta", 32'd0);
                step(STG_PUPD, "b_pupd", 32'd0);
            end
        end
        @(negedge clk);
        chk("b_done", 32'(done), 32'd1);
        chk("b_not_converged", 32'(converged), 32'd0);
        chk("b_iter3", 32'(iter_count), 32'd3);
        chk("b_busy_end", 32'(busy), 32'd0);

        // Watchdog: ALPHA never completes
        start_solve(32'd8, 16'd5);
        step(STG_RR0, "c_rr0", 32'h4000_0000);
        step(STG_AP, "c_ap", 32'd0);
        wait_stage(STG_ALPHA, "c_alpha_start");
        repeat (15) @(negedge clk);
        chk("c_error_early", 32'(error), 32'd0);
        chk("c_busy_early", 32'(busy), 32'd1);
        @(negedge clk);
        chk("c_error", 32'(error), 32'd1);
        chk("c_done", 32'(done), 32'd1);
        chk("c_busy", 32'(busy), 32'd0);
        chk("c_converged", 32'(converged), 32'd0);

        // Abort in UPD after one full iteration, then restart
        start_solve(32'd8, 16'd5);
        chk("d_error_cleared", 32'(error), 32'd0);
        step(STG_RR0, "d_rr0", 32'h4000_0000);
        step(STG_AP, "d_ap", 32'd0);
        step(STG_ALPHA, "d_alpha", 32'd0);
        step(STG_UPD, "d_upd", 32'd0);
        step(STG_RRNEW, "d_rrnew", 32'h3F80_0000);
        step(STG_BETA, "d_beta", 32'd0);
        step(STG_PUPD, "d_pupd", 32'd0);
        wait_stage(STG_AP, "d_ap2");
        chk("d_iter1", 32'(iter_count), 32'd1);
        pulse_done(STG_AP, 32'd0);
        step(STG_ALPHA, "d_alpha2", 32'd0);
        wait_stage(STG_UPD, "d_upd2_start");
        abort = 1'b1;
        @(negedge clk);
        chk("d_abort_busy", 32'(busy), 32'd0);
        chk("d_abort_done", 32'(done), 32'd1);
        chk("d_abort_conv", 32'(converged), 32'd0);
        chk("d_abort_start", 32'(bus.stage_start), 32'd0);
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("d_quiet", 32'(bus.stage_start), 32'd0);
        end
        chk("d_done_held", 32'(done), 32'd1);
        start_solve(32'd8, 16'd5);
        wait_stage(STG_RR0, "d_restart");
        chk("d_restart_iter", 32'(iter_count), 32'd0);
        chk("d_restart_done", 32'(done), 32'd0);
        chk("d_restart_busy", 32'(busy), 32'd1);

        // Reset mid-solve
        step(STG_RR0, "e_rr0", 32'h4000_0000);
        wait_stage(STG_AP, "e_ap");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("e_rst_busy", 32'(busy), 32'd0);
        chk("e_rst_done", 32'(done), 32'd0);
        chk("e_rst_rs_old", rs_old, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("e_rst_quiet", 32'(bus.stage_start), 32'd0);
            @(negedge clk);
        end

        // Degenerate lengths/limits finish immediately as converged
        start_solve(32'd0, 16'd5);
        chk("f_len0_done", 32'(done), 32'd1);
        chk("f_len0_conv", 32'(converged), 32'd1);
        chk("f_len0_busy", 32'(busy), 32'd0);
        chk("f_len0_start", 32'(bus.stage_start), 32'd0);
        start_solve(32'd8, 16'd0);
        chk("f_iter0_done", 32'(done), 32'd1);
        chk("f_iter0_conv", 32'(converged), 32'd1);
        chk("f_iter0_iter", 32'(iter_count), 32'd0);

        // Negative r.r counts as converged
        start_solve(32'd8, 16'd5);
        step(STG_RR0, "g_rr0", 32'h4000_0000);
        step(STG_AP, "g_ap", 32'd0);
        step(STG_ALPHA, "g_alpha", 32'd0);
        step(STG_UPD, "g_upd", 32'd0);
        step(STG_RRNEW, "g_rrnew", 32'hBF80_0000);
        @(negedge clk);
        chk("g_conv", 32'(converged), 32'd1);
        chk("g_iter", 32'(iter_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
